// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: address map, funct3 encodings,
// and the lane helpers used for byte enables, store replication and load extension.
package lsu_pkg;

  localparam logic [31:0] LEDR_BASE  = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE  = 32'h1000_1000;
  localparam logic [31:0] HEXLO_BASE = 32'h1000_2000;
  localparam logic [31:0] HEXHI_BASE = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE   = 32'h1000_4000;
  localparam logic [31:0] SW_BASE    = 32'h1001_0000;
  localparam logic [31:0] CYCLE_BASE = 32'h1002_0000;
  // Each I/O register is the single word at offset 0 of its window
  localparam logic [31:0] REG_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [3:0] {
    RG_NONE, RG_DMEM, RG_LEDR, RG_LEDG, RG_HEXLO, RG_HEXHI, RG_LCD, RG_SW, RG_CYCLE
  } region_e;

  function automatic logic [3:0] byte_en(input logic [1:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_lanes(input logic [31:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   st_lanes = {4{d[7:0]}};
      2'b01:   st_lanes = {2{d[15:0]}};
      default: st_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] ld_extend(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    ld_extend = {{24{sh[7]}}, sh[7:0]};
      F3_H:    ld_extend = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   ld_extend = {24'h0, sh[7:0]};
      F3_HU:   ld_extend = {16'h0, sh[15:0]};
      default: ld_extend = sh;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      merge[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: word array of 4 byte lanes, combinational read, byte-enabled write.
// Contents are deliberately not reset.
module lsu_dmem #(
  parameter int DMEM_BYTES = 2048
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [3:0]                    be,
  input  logic [$clog2(DMEM_BYTES)-3:0] word_addr,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata
);

  localparam int WORDS = DMEM_BYTES / 4;

  logic [3:0][7:0] mem [WORDS];

  assign rdata = mem[word_addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[word_addr][b] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/lsu.sv
// Load-store unit: address decode, alignment check, lane steering, board I/O registers.
// Define LSU_CYCLE_CNT_EN to add the read-only free-running cycle counter at CYCLE_BASE.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES  = 2048,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_funct3,
  output logic [31:0] o_ld_data,
  output logic        o_insn_vld,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw
);

  localparam int AW = $clog2(DMEM_BYTES);
  localparam logic [31:0] DMEM_HI_MASK = ~(32'(DMEM_BYTES) - 32'd1);

  region_e     region;
  logic        f3_ok, aligned, st_bad, legal, commit;
  logic [3:0]  be;
  logic [31:0] st_word, rd_word, dmem_rdata;
  logic [31:0] ledr, ledg, hex_lo, hex_hi, lcd;
  logic [31:0] sw_sync [SYNC_STAGES];

`ifdef LSU_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cycle_cnt <= '0;
    else          cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  always_comb begin
    region = RG_NONE;
    if ((i_lsu_addr & DMEM_HI_MASK) == 32'h0) begin
      region = RG_DMEM;
    end else begin
      case (i_lsu_addr & REG_MASK)
        LEDR_BASE:  region = RG_LEDR;
        LEDG_BASE:  region = RG_LEDG;
        HEXLO_BASE: region = RG_HEXLO;
        HEXHI_BASE: region = RG_HEXHI;
        LCD_BASE:   region = RG_LCD;
        SW_BASE:    region = RG_SW;
`ifdef LSU_CYCLE_CNT_EN
        CYCLE_BASE: region = RG_CYCLE;
`endif
        default:    region = RG_NONE;
      endcase
    end
  end

  always_comb begin
    f3_ok = 1'b0;
    case (i_lsu_funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_ok = 1'b1;
      default:                        f3_ok = 1'b0;
    endcase
  end

  assign aligned = (i_lsu_funct3[1:0] == 2'b01) ? !i_lsu_addr[0] :
                   (i_lsu_funct3[1:0] == 2'b10) ? (i_lsu_addr[1:0] == 2'b00) : 1'b1;
  // Unsigned encodings and read-only regions cannot be store targets
  assign st_bad  = i_lsu_wren && (i_lsu_funct3[2] || region == RG_SW || region == RG_CYCLE);
  assign legal   = (region != RG_NONE) && f3_ok && aligned && !st_bad;
  assign commit  = legal && i_lsu_wren && i_rst_n;
  assign be      = byte_en(i_lsu_addr[1:0], i_lsu_funct3);
  assign st_word = st_lanes(i_st_data, i_lsu_funct3);

  always_comb begin
    rd_word = '0;
    case (region)
      RG_DMEM:  rd_word = dmem_rdata;
      RG_LEDR:  rd_word = ledr;
      RG_LEDG:  rd_word = ledg;
      RG_HEXLO: rd_word = hex_lo;
      RG_HEXHI: rd_word = hex_hi;
      RG_LCD:   rd_word = lcd;
      RG_SW:    rd_word = sw_sync[SYNC_STAGES-1];
`ifdef LSU_CYCLE_CNT_EN
      RG_CYCLE: rd_word = cycle_cnt;
`endif
      default:  rd_word = '0;
    endcase
  end

  assign o_insn_vld = legal;
  assign o_ld_data  = legal ? ld_extend(rd_word, i_lsu_addr[1:0], i_lsu_funct3) : 32'h0;

  lsu_dmem #(.DMEM_BYTES(DMEM_BYTES)) u_dmem (
    .clk       (i_clk),
    .we        (commit && region == RG_DMEM),
    .be        (be),
    .word_addr (i_lsu_addr[AW-1:2]),
    .wdata     (st_word),
    .rdata     (dmem_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr   <= '0;
      ledg   <= '0;
      hex_lo <= '0;
      hex_hi <= '0;
      lcd    <= '0;
    end else if (commit) begin
      case (region)
        RG_LEDR:  ledr   <= merge(ledr, st_word, be);
        RG_LEDG:  ledg   <= merge(ledg, st_word, be);
        RG_HEXLO: hex_lo <= merge(hex_lo, st_word, be);
        RG_HEXHI: hex_hi <= merge(hex_hi, st_word, be);
        RG_LCD:   lcd    <= merge(lcd, st_word, be);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sw_sync[s] <= '0;
    end else begin
      sw_sync[0] <= i_io_sw;
      for (int s = 1; s < SYNC_STAGES; s++) sw_sync[s] <= sw_sync[s-1];
    end
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;
  assign o_io_hex0 = hex_lo[6:0];
  assign o_io_hex1 = hex_lo[14:8];
  assign o_io_hex2 = hex_lo[22:16];
  assign o_io_hex3 = hex_lo[30:24];
  assign o_io_hex4 = hex_hi[6:0];
  assign o_io_hex5 = hex_hi[14:8];
  assign o_io_hex6 = hex_hi[22:16];
  assign o_io_hex7 = hex_hi[30:24];

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of access vectors with hand-computed results,
// plus sequences for reset, switch synchronizer and cycle counter timing.
module tb_lsu;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, st_data, sw;
  logic        wren;
  logic [2:0]  f3;
  logic [31:0] ld_data, ledr, ledg, lcd;
  logic        insn_vld;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  lsu #(.DMEM_BYTES(2048), .SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr), .i_st_data(st_data),
    .i_lsu_wren(wren), .i_lsu_funct3(f3), .o_ld_data(ld_data), .o_insn_vld(insn_vld),
    .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
    .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
    .o_io_lcd(lcd), .i_io_sw(sw)
  );

  typedef struct {
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] st;
    logic        vld;
    logic        chk_ld;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic [2:0] fn, input logic [31:0] a,
                              input logic [31:0] s, input logic v, input logic c,
                              input logic [31:0] l);
    vec_t r;
    r.wren = w; r.f3 = fn; r.addr = a; r.st = s; r.vld = v; r.chk_ld = c; r.ld = l;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] s);
    wren = w; f3 = fn; addr = a; st_data = s;
  endtask

  task automatic chk_io_zero(input string tag);
    chk({tag, " ledr"}, ledr, 32'h0);
    chk({tag, " ledg"}, ledg, 32'h0);
    chk({tag, " lcd"},  lcd,  32'h0);
    chk({tag, " hex"},  {4'h0, hex7, hex6, hex5, hex4}, 32'h0);
    chk({tag, " hexlo"}, {4'h0, hex3, hex2, hex1, hex0}, 32'h0);
  endtask

  initial begin
    logic [31:0] c1;

    // W: store, reads pre-store; B/H/BU/HU lanes
    tbl.push_back(mk(1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1, 0, 32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0, 1, 1, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 3'b000, 32'h13, 32'h0, 1, 1, 32'hFFFF_FFDE));
    tbl.push_back(mk(0, 3'b100, 32'h10, 32'h0, 1, 1, 32'h0000_00EF));
    tbl.push_back(mk(0, 3'b001, 32'h12, 32'h0, 1, 1, 32'hFFFF_DEAD));
    tbl.push_back(mk(0, 3'b101, 32'h10, 32'h0, 1, 1, 32'h0000_BEEF));
    // SB into lane 1: same-cycle read sees old byte
    tbl.push_back(mk(1, 3'b000, 32'h11, 32'h0000_00AA, 1, 1, 32'hFFFF_FFBE));
    tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0, 1, 1, 32'hDEAD_AAEF));
    tbl.push_back(mk(1, 3'b010, 32'h10, 32'h0123_4567, 1, 1, 32'hDEAD_AAEF));
    tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0, 1, 1, 32'h0123_4567));
    tbl.push_back(mk(1, 3'b001, 32'h12, 32'h1234_5678, 1, 1, 32'h0000_0123));
    tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0, 1, 1, 32'h5678_4567));
    tbl.push_back(mk(0, 3'b001, 32'h12, 32'h0, 1, 1, 32'h0000_5678));
    // illegal accesses leave memory alone
    tbl.push_back(mk(1, 3'b010, 32'h0, 32'h0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h2, 32'h0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 3'b001, 32'h1, 32'hFFFF_FFFF, 0, 1, 32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h2000_0000, 32'h0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 3'b001, 32'h11, 32'h0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 3'b011, 32'h10, 32'h0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 3'b110, 32'h10, 32'h0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 3'b100, 32'h10, 32'hFFFF_FFFF, 0, 1, 32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h0, 32'h0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0, 1, 1, 32'h5678_4567));
    // top of DMEM and first byte past it
    tbl.push_back(mk(1, 3'b010, 32'h7FC, 32'hCAFE_F00D, 1, 0, 32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h7FC, 32'h0, 1, 1, 32'hCAFE_F00D));
    tbl.push_back(mk(0, 3'b000, 32'h800, 32'h0, 0, 1, 32'h0));
    // I/O registers
    tbl.push_back(mk(1, 3'b010, 32'h1000_2000, 32'h7F3F_063F, 1, 1, 32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h1000_2000, 32'h0, 1, 1, 32'h7F3F_063F));
    tbl.push_back(mk(0, 3'b010, 32'h1000_2004, 32'h0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 3'b010, 32'h1000_0000, 32'h1234_5678, 1, 1, 32'h0));
    tbl.push_back(mk(1, 3'b010, 32'h1000_1000, 32'h0000_FFFF, 1, 1, 32'h0));
    tbl.push_back(mk(1, 3'b000, 32'h1000_3001, 32'h0000_0055, 1, 1, 32'h0));
    tbl.push_back(mk(1, 3'b010, 32'h1000_4000, 32'hA5A5_A5A5, 1, 1, 32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h1000_0000, 32'h0, 1, 1, 32'h1234_5678));
    tbl.push_back(mk(0, 3'b100, 32'h1000_3001, 32'h0, 1, 1, 32'h0000_0055));
    tbl.push_back(mk(1, 3'b010, 32'h1001_0000, 32'h0, 0, 1, 32'h0));

    rst_n = 1'b0;
    sw    = 32'h0;
    drive(0, 3'b010, 32'h0, 32'h0);
    #12;
    chk_io_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].wren, tbl[i].f3, tbl[i].addr, tbl[i].st);
      #1;
      chk($sformatf("vec%0d vld", i), {31'h0, insn_vld}, {31'h0, tbl[i].vld});
      if (tbl[i].chk_ld) chk($sformatf("vec%0d ld", i), ld_data, tbl[i].ld);
    end
    @(negedge clk);
    drive(0, 3'b010, 32'h10, 32'h0);
    #1;
    chk("hex0", {25'h0, hex0}, 32'h3F);
    chk("hex1", {25'h0, hex1}, 32'h06);
    chk("hex2", {25'h0, hex2}, 32'h3F);
    chk("hex3", {25'h0, hex3}, 32'h7F);
    chk("hex4", {25'h0, hex4}, 32'h00);
    chk("hex5", {25'h0, hex5}, 32'h55);
    chk("ledr", ledr, 32'h1234_5678);
    chk("ledg", ledg, 32'h0000_FFFF);
    chk("lcd",  lcd,  32'hA5A5_A5A5);

    // async reset between edges while a store is presented, held across an edge
    @(negedge clk);
    drive(1, 3'b010, 32'h1000_0000, 32'hFFFF_FFFF);
    #2 rst_n = 1'b0;
    #1;
    chk_io_zero("midreset");
    @(posedge clk);
    #1;
    chk("ledr held", ledr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 3'b010, 32'h10, 32'h0);
    #1;
    chk("dmem kept", ld_data, 32'h5678_4567);
    @(negedge clk);
    chk("ledr post", ledr, 32'h0);

    // switch synchronizer depth
    drive(0, 3'b010, 32'h1001_0000, 32'h0);
    sw = 32'h0000_00A5;
    for (int k = 0; k <= SYNC; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      chk($sformatf("sw after %0d edges", k), ld_data, (k == SYNC) ? 32'hA5 : 32'h0);
    end
    @(negedge clk);
    drive(1, 3'b010, 32'h1001_0000, 32'h1);
    #1;
    chk("sw store vld", {31'h0, insn_vld}, 32'h0);

    // cycle counter
    @(negedge clk);
    drive(0, 3'b010, 32'h1002_0000, 32'h0);
    #1;
`ifdef LSU_CYCLE_CNT_EN
    chk("cycle vld", {31'h0, insn_vld}, 32'h1);
    c1 = ld_data;
    repeat (7) @(posedge clk);
    #1;
    chk("cycle delta", ld_data - c1, 32'd7);
`else
    c1 = ld_data;
    chk("cycle vld", {31'h0, insn_vld}, 32'h0);
    chk("cycle ld", c1, 32'h0);
`endif

    @(negedge clk);
    drive(0, 3'b010, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load-store unit for the single-cycle RV32I core; sits directly downstream of the ALU, taking the ALU result as the effective address. It decodes the address into data memory or memory-mapped I/O, performs byte/half/word stores on the clock edge, returns sign- or zero-extended load data combinationally in the same cycle, and owns the board I/O registers (LEDs, 7-segment, LCD, switches).

## Interface
- DMEM_BYTES, 2048: data memory size in bytes, power of two, based at 0x0000_0000
- SYNC_STAGES, 2: switch-input synchronizer depth (≥2)
- i_clk  input  1  core clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_lsu_addr  input  32  effective address (ALU o_alu_data)
- i_st_data  input  32  store data (rs2)
- i_lsu_wren  input  1  store request this cycle
- i_lsu_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- o_ld_data  output  32  load data, extended per funct3
- o_insn_vld  output  1  access legal (mapped, aligned, valid funct3)
- o_io_ledr, o_io_ledg  output  32 each  red/green LED registers
- o_io_hex0..o_io_hex7  output  7 each  7-segment digits, bits [6:0] of each byte of HEX_LO/HEX_HI
- o_io_lcd  output  32  LCD register
- i_io_sw  input  32  raw asynchronous switches

## Operation
- Address map (word-aligned base, 4 KiB window each): DMEM 0x0000_0000..DMEM_BYTES-1; LEDR 0x1000_0000; LEDG 0x1000_1000; HEX_LO 0x1000_2000 (hex0–3); HEX_HI 0x1000_3000 (hex4–7); LCD 0x1000_4000; SW 0x1001_0000 (RO); CYCLE 0x1002_0000 (RO, see Configuration). Only offset 0 within an I/O window is the register; other offsets unmapped.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0. B always aligned.
- Stores: funct3 000/001/010 only; byte enables derived from addr[1:0] and size; data replicated to lane. Applied identically to DMEM and RW I/O registers.
- Loads: selected lane shifted to bit 0, sign-extended (B/H) or zero-extended (BU/HU). Read is combinational.
- Illegal (unmapped, misaligned, funct3 011/110/111, store with funct3 1xx, store to RO region): o_insn_vld=0, no state change, o_ld_data=0. Legal: o_insn_vld=1. With i_lsu_wren=0 the block still drives o_ld_data/o_insn_vld for the presented address.
- Switches: SYNC_STAGES flop chain; SW load returns last stage.

## Timing
- Load latency 0 cycles (combinational address→o_ld_data); store takes effect at next rising edge.
- Store and load to same address in same cycle: load returns pre-store value; new value visible following cycle.
- Switch change visible on SW load after exactly SYNC_STAGES rising edges.
- Reset (asynchronous assert, any time, including mid-store): LEDR, LEDG, HEX_LO, HEX_HI, LCD, sync chain, CYCLE → 0 immediately; all o_io_* = 0. DMEM contents not reset (undefined until written). Store in the cycle reset deasserts at an edge is not committed if i_rst_n low at that edge.
- o_ld_data/o_insn_vld are combinational; no reset value beyond their inputs.

## Configuration
- LSU_CYCLE_CNT_EN defined: 32-bit free-running cycle counter, reset 0, +1 every edge, wraps 0xFFFF_FFFF→0; readable at CYCLE (W/H/B legal), stores ignored and flagged illegal.
- Undefined: no counter logic; CYCLE address is unmapped (o_insn_vld=0, o_ld_data=0).

## Structure
- lsu_pkg: region base addresses, window mask, funct3 encodings (enum), byte-enable/extension helper functions.
- Sub-module lsu_dmem: DMEM_BYTES array, 4 byte lanes, combinational read, byte-enabled synchronous write, no reset.
- Top: decode, alignment check, lane steering, I/O registers, synchronizer, optional counter.

## Test plan
- SW 0x0000_0010 ← 0xDEADBEEF; LB 0x13 → 0xFFFF_FFDE; LBU 0x10 → 0x0000_00EF; LH 0x12 → 0xFFFF_DEAD; LHU 0x10 → 0x0000_BEEF; all o_insn_vld=1.
- SB 0x11 ← 0x000000AA over 0xDEADBEEF → LW 0x10 = 0xDEADAAEF; same-cycle LW returns 0xDEADBEEF.
- LW 0x0000_0002, SH 0x0000_0001, LW 0x2000_0000 → o_insn_vld=0, o_ld_data=0, memory unchanged.
- SW 0x1000_2000 ← 0x7F3F063F → hex0=0x3F, hex1=0x06, hex2=0x3F, hex3=0x7F; assert i_rst_n=0 between edges → all hex/LED outputs 0 immediately.
- i_io_sw=0x0000_00A5 at cycle N → LW 0x1001_0000 reads old value until edge N+SYNC_STAGES, then 0xA5; SW to 0x1001_0000 → o_insn_vld=0.
- With LSU_CYCLE_CNT_EN: two LW of 0x1002_0000 k cycles apart differ by k; without: o_insn_vld=0.
